tone_generator: RTL

TONE_GENERATOR -- requirements
Module: tone_generator

---
 rtl/tone_generator.sv | 114 +++++++++++
 1 files changed

// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - square-wave tone generator with envelope FSM; ramps enabled by macro TONE_ENVELOPE_EN
module tone_generator #(
  parameter int PHASE_K      = 350,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] frequency,
  input  logic        gate,
  input  logic        sample_req,
  output logic [23:0] sample,
  output logic        sample_valid,
  output logic        active,
  output logic [7:0]  env_level
);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  env_q, env_d;
  logic [23:0] phase_q, phase_d;
  logic [23:0] sample_q, sample_d;
  logic        sample_valid_q;

  logic [23:0] inc;
  logic [31:0] env_up_w;
  logic [7:0]  env_up;
  logic [7:0]  env_dn;
  logic [23:0] mag;

  // Phase increment: a 24-bit-wide product keeps exactly the low 24 bits of the full product
  assign inc = 24'(frequency) * 24'(PHASE_K);

  // Saturating envelope ramps and the square-wave magnitude of the current envelope
  always_comb begin
    env_up_w = {24'd0, env_q} + 32'(ATTACK_STEP);
    env_up   = (env_up_w >= 32'd255) ? 8'hFF : env_up_w[7:0];
    env_dn   = ({24'd0, env_q} <= 32'(RELEASE_STEP)) ? 8'd0 : env_q - 8'(RELEASE_STEP);
    mag      = {1'b0, env_q, 15'd0};
  end

  // Next-state: everything advances only on a sample request, using pre-update phase/env for the output
  always_comb begin
    state_d  = state_q;
    env_d    = env_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    if (sample_req) begin
      phase_d = (state_q == IDLE) ? 24'd0 : phase_q + inc;
      if (env_q == 8'd0 || frequency == 16'd0) begin
        sample_d = 24'd0;
      end else begin
        sample_d = phase_q[23] ? (24'd0 - mag) : mag;
      end
      case (state_q)
`ifdef TONE_ENVELOPE_EN
        IDLE: begin
          if (gate) begin
            state_d = ATTACK;
            env_d   = 8'd0;
          end
        end
        SUSTAIN: begin
          if (gate) begin
            env_d = 8'hFF;
          end else begin
            env_d   = env_dn;
            state_d = (env_dn == 8'd0) ? IDLE : RELEASE;
          end
        end
`else
        IDLE, SUSTAIN: begin
          state_d = gate ? SUSTAIN : IDLE;
          env_d   = gate ? 8'hFF : 8'd0;
        end
`endif
        // Ramp states; a gate change reverses direction from the current level
        default: begin
          if (gate) begin
            env_d   = env_up;
            state_d = (env_up == 8'hFF) ? SUSTAIN : ATTACK;
          end else begin
            env_d   = env_dn;
            state_d = (env_dn == 8'd0) ? IDLE : RELEASE;
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset wins over a coincident request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      env_q          <= 8'd0;
      phase_q        <= 24'd0;
      sample_q       <= 24'd0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      env_q          <= env_d;
      phase_q        <= phase_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_req;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign active       = (state_q != IDLE);
  assign env_level    = env_q;

endmodule
